bp_stall_counter_bank: RTL

- Synthesizable accumulator downstream of the core stall profiler.
- Consumes the per-cycle stream of retire/stall-reason samples (instret flag + encoded stall reason) and keeps one counter per reason, plus cycle and instret totals.
- Provides atomic snapshot/clear and a valid/yumi read port, so the Zynq host shell can read stall histograms over its CSR path without simulation-only constructs.

---
 rtl/bp_stall_counter_bank.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bp_stall_counter_bank.sv
// bp_stall_counter_bank: per-reason stall histogram with cycle/instret totals,
// atomic snapshot/clear into a shadow bank, and a valid/yumi read port over
// the shadow bank.
//
// Counter index map (live and shadow banks share it, as does the read address):
//   0 .. num_reasons_p-1  stall-reason counters
//   num_reasons_p         cycle counter
//   num_reasons_p+1       instret counter
//
// Build option: define BP_STALL_CNT_SATURATE_EN to make counters saturate at
// all-ones and raise the sticky sat_o. Otherwise counters wrap and sat_o is 0.

// Single live counter cell: increment, synchronous clear, overflow policy.
module bp_stall_ctr_cell #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_li,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output logic [cnt_width_p-1:0] cnt_o,
  output logic                   sat_hit_o
);
  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  // Next count: clear beats increment; overflow handling depends on the build.
  always_comb begin
    cnt_d     = cnt_q;
    sat_hit_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
`ifdef BP_STALL_CNT_SATURATE_EN
      if (&cnt_q) sat_hit_o = 1'b1;
      else        cnt_d     = cnt_q + cnt_width_p'(1);
`else
      cnt_d = cnt_q + cnt_width_p'(1);
`endif
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module bp_stall_counter_bank #(
  parameter int num_reasons_p  = 32,
  parameter int reason_width_p = 5,
  parameter int cnt_width_p    = 32,
  parameter int addr_width_p   = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_li,
  input  logic                      en_i,
  input  logic                      v_i,
  input  logic                      instret_i,
  input  logic [reason_width_p-1:0] reason_i,
  input  logic                      snap_i,
  input  logic                      clear_i,
  input  logic                      rd_v_i,
  input  logic [addr_width_p-1:0]   rd_addr_i,
  input  logic                      rd_yumi_i,
  output logic                      rd_ready_o,
  output logic                      rd_data_v_o,
  output logic [cnt_width_p-1:0]    rd_data_o,
  output logic                      rd_err_o,
  output logic                      bad_reason_o,
  output logic                      sat_o
);
  localparam int num_ctr_lp = num_reasons_p + 2;
  localparam int cyc_idx_lp = num_reasons_p;
  localparam int ins_idx_lp = num_reasons_p + 1;

  typedef enum logic {RD_IDLE, RD_VALID} rd_state_e;

  logic [num_ctr_lp-1:0][cnt_width_p-1:0] live, shadow_q;
  logic [num_ctr_lp-1:0]                  inc, sat_hit;
  logic                                   count_en, reason_ok;
  logic                                   bad_q;
  rd_state_e                              rd_state_q;
  logic [cnt_width_p-1:0]                 rd_data_q, rd_sel;
  logic                                   rd_err_q, rd_oob;

  // A clear in the same cycle drops the concurrent sample.
  assign count_en  = en_i & v_i & ~clear_i;
  assign reason_ok = (32'(reason_i) < 32'(num_reasons_p));

  // Increment enables: cycle always, then exactly one of instret / reason.
  always_comb begin
    inc = '0;
    for (int i = 0; i < num_reasons_p; i++)
      inc[i] = count_en & ~instret_i & (32'(reason_i) == 32'(i));
    inc[cyc_idx_lp] = count_en;
    inc[ins_idx_lp] = count_en & instret_i;
  end

  for (genvar g = 0; g < num_ctr_lp; g++) begin : g_ctr
    bp_stall_ctr_cell #(.cnt_width_p(cnt_width_p)) u_cell (
      .clk_i     (clk_i),
      .reset_li  (reset_li),
      .inc_i     (inc[g]),
      .clr_i     (clear_i),
      .cnt_o     (live[g]),
      .sat_hit_o (sat_hit[g])
    );
  end

  // Snapshot takes the registered live values, i.e. before this cycle's update.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)   shadow_q <= '0;
    else if (snap_i) shadow_q <= live;
  end

  // Sticky flag: an out-of-range reason was counted as a sample.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)                         bad_q <= 1'b0;
    else if (count_en & ~instret_i & ~reason_ok) bad_q <= 1'b1;
  end

`ifdef BP_STALL_CNT_SATURATE_EN
  logic sat_q;
  // Sticky flag: some counter was asked to increment past all-ones.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)     sat_q <= 1'b0;
    else if (|sat_hit) sat_q <= 1'b1;
  end
  assign sat_o = sat_q;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = |sat_hit;
  assign sat_o          = 1'b0;
`endif

  // Shadow read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < num_ctr_lp; i++)
      if (rd_addr_i == addr_width_p'(i)) rd_sel = shadow_q[i];
  end
  assign rd_oob = (32'(rd_addr_i) > 32'(ins_idx_lp));

  // Read FSM: latch on acceptance in IDLE, hold in VALID until yumi.
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      rd_state_q <= RD_IDLE;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (rd_v_i) begin
          rd_state_q <= RD_VALID;
          rd_data_q  <= rd_sel;
          rd_err_q   <= rd_oob;
        end
        RD_VALID: if (rd_yumi_i) rd_state_q <= RD_IDLE;
        default:  rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign rd_ready_o   = (rd_state_q == RD_IDLE);
  assign rd_data_v_o  = (rd_state_q == RD_VALID);
  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;
  assign bad_reason_o = bad_q;
endmodule
